// File: rtl/m_uart_loader_pkg.sv
// Shared encodings and 8N1 frame constants for the UART program loader.
package m_uart_loader_pkg;

  localparam int   CLKS_PER_BIT_DEF = 434;
  localparam int   FRAME_DATA_BITS  = 8;
  localparam logic FRAME_IDLE_LVL   = 1'b1;
  localparam logic FRAME_START_LVL  = 1'b0;
  localparam logic FRAME_STOP_LVL   = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_WORD,
    S_DONE,
    S_ERR
  } ld_state_e;

endpackage

// File: rtl/m_uart_loader_if.sv
// Memory write port driven by the loader into the instruction/data memory.
interface m_uart_loader_if #(
  parameter int ADDR_W = 12
);
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  modport master (output r_we, output r_addr, output r_wdata);
  modport slave  (input  r_we, input  r_addr, input  r_wdata);
endinterface

// File: rtl/m_uart_loader_rx.sv
// 8N1 receiver: 2-flop synchroniser, then a mid-bit sampling bit engine.
// RX_IDLE wait for low | RX_START confirm start at half bit | RX_DATA 8 data bits | RX_STOP check stop
module m_uart_rx
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rxd_s_q, rxd_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    sync1_d      = w_rxd;
    rxd_s_d      = sync1_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rxd_s_q == FRAME_START_LVL) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxd_s_q == FRAME_START_LVL) begin
          state_d = RX_DATA;
          cnt_d   = FULL_M1;
          bit_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == LAST_BIT) state_d = RX_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RX_IDLE;
          if (rxd_s_q == FRAME_STOP_LVL) byte_valid_d = 1'b1;
          else frame_err_d = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q      <= RX_IDLE;
      sync1_q      <= FRAME_IDLE_LVL;
      rxd_s_q      <= FRAME_IDLE_LVL;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      rxd_s_q      <= rxd_s_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/m_uart_loader.sv
// UART program loader: 16-bit LE length, then LE 32-bit words written from address 0.
// S_IDLE wait length lo | S_LEN_HI length hi + check | S_WORD assemble/write | S_DONE finish | S_ERR hold until reset
module m_uart_loader
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 12
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  m_uart_loader_if.master   mem,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err
);

  localparam int          IDX_W   = ADDR_W + 1;
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_rxd      (w_rxd),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  ld_state_e         state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [15:0]      len_full;
  logic [31:0]      word_next;
  logic [IDX_W-1:0] idx_inc;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;

    len_full  = {rx_byte, len_q[7:0]};
    word_next = word_q;
    word_next[{bcnt_q, 3'b000} +: 8] = rx_byte;
    idx_inc   = idx_q + IDX_W'(1);

    case (state_q)
      S_IDLE: begin
        if (byte_valid) begin
          len_d   = {8'h00, rx_byte};
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (frame_err) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (byte_valid) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, len_full} > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            idx_d   = '0;
            bcnt_d  = '0;
            state_d = S_WORD;
          end
        end
      end
      S_WORD: begin
        if (frame_err) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (byte_valid) begin
          word_d = word_next;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = word_next;
            idx_d   = idx_inc;
            bcnt_d  = '0;
            if (16'(idx_inc) == len_q) state_d = S_DONE;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      // Entered in the same cycle the final write strobe is registered.
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem.r_we    = we_q;
  assign mem.r_addr  = addr_q;
  assign mem.r_wdata = wdata_q;
  assign r_busy      = busy_q;
  assign r_done      = done_q;
  assign r_err       = err_q;

endmodule
